// File: rtl/mux_nx1_rr_reg_pkg.sv
// Shared constants and types for the registered N-to-1 round-robin multiplexer.
// Default geometry is 4 channels of 8 bits; the select/index width must equal ceil(log2(N_CH)).
package mux_nx1_rr_reg_pkg;

   typedef enum logic {
      MODE_SEL = 1'b0,
      MODE_RR  = 1'b1
   } mode_e;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_N_CH  = 4;
   localparam int DEF_SEL_W = 2;

endpackage

// File: rtl/mux_nx1_rr_reg_rr_arbiter.sv
// Combinational round-robin search: starting just above ptr and wrapping at N_CH-1,
// the first requesting channel wins.
module rr_arbiter
   import mux_nx1_rr_reg_pkg::*;
#(
   parameter int N_CH  = DEF_N_CH,
   parameter int SEL_W = DEF_SEL_W
) (
   input  logic [N_CH-1:0]  req,
   input  logic [SEL_W-1:0] ptr,
   output logic [SEL_W-1:0] grant,
   output logic             grant_valid
);

   logic [SEL_W-1:0] w_idx;

   always_comb begin
      grant       = '0;
      grant_valid = 1'b0;
      w_idx       = ptr;
      // The pointer itself is visited last, so the previous winner has lowest priority.
      for (int i = 0; i < N_CH; i++) begin
         w_idx = (w_idx == SEL_W'(N_CH - 1)) ? '0 : w_idx + 1'b1;
         if (!grant_valid && req[w_idx]) begin
            grant       = w_idx;
            grant_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_nx1_rr_reg.sv
// Registered N-to-1 data multiplexer with valid/ready handshake on both sides.
// Grant comes from the explicit select or from the round-robin arbiter, chosen per cycle by mode_rr.
module mux_nx1_rr_reg
   import mux_nx1_rr_reg_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int N_CH  = DEF_N_CH,
   parameter int SEL_W = DEF_SEL_W
) (
   input  logic                  clock,
   input  logic                  reset_b,
   input  logic [N_CH*WIDTH-1:0] in_data,
   input  logic [N_CH-1:0]       in_valid,
   output logic [N_CH-1:0]       in_ready,
   input  logic                  mode_rr,
   input  logic [SEL_W-1:0]      select,
   output logic [WIDTH-1:0]      out_data,
   output logic [SEL_W-1:0]      out_ch,
   output logic                  out_valid,
   input  logic                  out_ready
);

   // Handshake: a word moves on a side only in a cycle where its valid and ready are both high.
   // Upstream holds data/valid until in_ready; the output register holds its word until out_ready.

   logic [WIDTH-1:0] r_out_data;
   logic [SEL_W-1:0] r_out_ch;
   logic             r_out_valid;
   logic [SEL_W-1:0] r_rr_ptr;

   mode_e            w_mode;
   logic [SEL_W-1:0] w_arb_grant;
   logic             w_arb_valid;
   logic             w_sel_valid;
   logic [SEL_W-1:0] w_grant;
   logic             w_grant_valid;
   logic             w_load;
   logic             w_transfer;
   logic [WIDTH-1:0] w_data;

   assign w_mode = mode_e'(mode_rr);

   rr_arbiter #(
      .N_CH  (N_CH),
      .SEL_W (SEL_W)
   ) u_rr_arbiter (
      .req         (in_valid),
      .ptr         (r_rr_ptr),
      .grant       (w_arb_grant),
      .grant_valid (w_arb_valid)
   );

   // An out-of-range select matches no channel and therefore never grants.
   always_comb begin
      w_sel_valid = 1'b0;
      for (int k = 0; k < N_CH; k++) begin
         if (select == SEL_W'(k)) begin
            w_sel_valid = in_valid[k];
         end
      end
   end

   assign w_grant       = (w_mode == MODE_RR) ? w_arb_grant : select;
   assign w_grant_valid = (w_mode == MODE_RR) ? w_arb_valid : w_sel_valid;

   // Nothing is accepted while reset is held, even though load would otherwise be high.
   assign w_load     = !r_out_valid || out_ready;
   assign w_transfer = reset_b && w_load && w_grant_valid;

   always_comb begin
      w_data   = '0;
      in_ready = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (w_grant == SEL_W'(k)) begin
            w_data      = in_data[k*WIDTH +: WIDTH];
            in_ready[k] = w_transfer;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_b) begin
      if (!reset_b) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_ch    <= '0;
         r_rr_ptr    <= SEL_W'(N_CH - 1);
      end else begin
         if (w_transfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_data;
            r_out_ch    <= w_grant;
            if (w_mode == MODE_RR) begin
               r_rr_ptr <= w_grant;
            end
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_data  = r_out_data;
   assign out_ch    = r_out_ch;
   assign out_valid = r_out_valid;

endmodule

// File: tb/tb_mux_nx1_rr_reg.sv
// Bench for mux_nx1_rr_reg: directed vectors, a cycle model of the handshake rules and a word scoreboard.
module tb_mux_nx1_rr_reg;

   localparam int WIDTH = 8;
   localparam int N_CH  = 4;
   localparam int SEL_W = 2;

   logic                  clock = 1'b0;
   logic                  reset_b = 1'b1;
   logic [N_CH*WIDTH-1:0] in_data;
   logic [N_CH-1:0]       in_valid;
   logic [N_CH-1:0]       in_ready;
   logic                  mode_rr;
   logic [SEL_W-1:0]      select;
   logic [WIDTH-1:0]      out_data;
   logic [SEL_W-1:0]      out_ch;
   logic                  out_valid;
   logic                  out_ready;

   int n_checks = 0;
   int n_fail   = 0;

   logic [SEL_W+WIDTH-1:0] exp_q[$];

   logic             m_valid = 1'b0;
   logic [WIDTH-1:0] m_data  = '0;
   logic [SEL_W-1:0] m_ch    = '0;
   int               m_ptr   = N_CH - 1;
   bit               pend    = 1'b0;
   logic             n_valid;
   logic [WIDTH-1:0] n_data;
   logic [SEL_W-1:0] n_ch;
   int               n_ptr;

   int seq3[5] = '{0, 1, 2, 3, 0};

   mux_nx1_rr_reg #(
      .WIDTH (WIDTH),
      .N_CH  (N_CH),
      .SEL_W (SEL_W)
   ) dut (
      .clock     (clock),
      .reset_b   (reset_b),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mode_rr   (mode_rr),
      .select    (select),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   // ---------------- clock ----------------
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   // ---------------- check helper ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- per-cycle model compare (called at every negedge) ----------------
   task automatic compare_cycle();
      int                     g;
      bit                     gv;
      bit                     xfer;
      logic [N_CH-1:0]        er;
      logic [WIDTH-1:0]       lane;
      logic [SEL_W+WIDTH-1:0] w;
      if (!reset_b) begin
         m_valid = 1'b0;
         m_data  = '0;
         m_ch    = '0;
         m_ptr   = N_CH - 1;
         pend    = 1'b0;
         exp_q.delete();
         chk("rst_out_valid", 32'(out_valid), 32'(0));
         chk("rst_out_data", 32'(out_data), 32'(0));
         chk("rst_out_ch", 32'(out_ch), 32'(0));
         chk("rst_in_ready", 32'(in_ready), 32'(0));
         return;
      end
      if (pend) begin
         m_valid = n_valid;
         m_data  = n_data;
         m_ch    = n_ch;
         m_ptr   = n_ptr;
         pend    = 1'b0;
      end
      chk("model_out_valid", 32'(out_valid), 32'(m_valid));
      chk("model_out_data", 32'(out_data), 32'(m_data));
      chk("model_out_ch", 32'(out_ch), 32'(m_ch));

      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_word: got 0x%0h, expected no word", {out_ch, out_data});
         end else begin
            w = exp_q.pop_front();
            chk("sb_word", 32'({out_ch, out_data}), 32'(w));
         end
      end

      // Winner: RR takes the lowest valid channel above the pointer, else the lowest valid overall.
      g  = 0;
      gv = 1'b0;
      if (mode_rr) begin
         for (int k = 0; k < N_CH; k++)
            if (!gv && k > m_ptr && in_valid[k]) begin g = k; gv = 1'b1; end
         for (int k = 0; k < N_CH; k++)
            if (!gv && in_valid[k]) begin g = k; gv = 1'b1; end
      end else begin
         g = int'(select);
         for (int k = 0; k < N_CH; k++)
            if (k == g) gv = in_valid[k];
      end
      xfer = (!m_valid || out_ready) && gv;

      er   = '0;
      lane = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (k == g) begin
            er[k] = xfer;
            lane  = in_data[k*WIDTH +: WIDTH];
         end
      end
      chk("model_in_ready", 32'(in_ready), 32'(er));

      n_valid = m_valid;
      n_data  = m_data;
      n_ch    = m_ch;
      n_ptr   = m_ptr;
      if (xfer) begin
         n_valid = 1'b1;
         n_data  = lane;
         n_ch    = SEL_W'(g);
         if (mode_rr) n_ptr = g;
         exp_q.push_back({SEL_W'(g), lane});
      end else if (out_ready) begin
         n_valid = 1'b0;
      end
      pend = 1'b1;
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(negedge clock);
      compare_cycle();
      @(posedge clock);
      #2;
   endtask

   task automatic set_data(input logic [7:0] d0, input logic [7:0] d1,
                           input logic [7:0] d2, input logic [7:0] d3);
      in_data = {d3, d2, d1, d0};
   endtask

   // ---------------- stimulus ----------------
   initial begin
      mode_rr   = 1'b0;
      select    = '0;
      in_valid  = 4'hF;
      out_ready = 1'b0;
      set_data(8'h01, 8'h02, 8'h03, 8'h04);

      // Asynchronous reset takes effect without a clock edge
      #1 reset_b = 1'b0;
      #2;
      chk("t1_out_valid", 32'(out_valid), 32'(0));
      chk("t1_in_ready", 32'(in_ready), 32'(0));
      chk("t1_out_data", 32'(out_data), 32'(0));
      tick();
      tick();

      // Select mode, channel 2
      reset_b   = 1'b1;
      mode_rr   = 1'b0;
      select    = 2'd2;
      in_valid  = 4'b0100;
      out_ready = 1'b1;
      set_data(8'h00, 8'h00, 8'hA5, 8'h00);
      #1 chk("t2_in_ready", 32'(in_ready), 32'(4'b0100));
      tick();
      chk("t2_out_data", 32'(out_data), 32'(8'hA5));
      chk("t2_out_ch", 32'(out_ch), 32'(2));
      chk("t2_out_valid", 32'(out_valid), 32'(1));
      in_valid = 4'b0000;
      tick();

      // Round-robin, all channels valid
      mode_rr  = 1'b1;
      in_valid = 4'hF;
      set_data(8'h10, 8'h11, 8'h12, 8'h13);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t3_out_ch", 32'(out_ch), 32'(seq3[i]));
         chk("t3_out_data", 32'(out_data), 32'(8'h10 + seq3[i]));
      end

      // Round-robin wrap with channels 0 and 3
      in_valid = 4'b1001;
      tick();
      chk("t4_grant_a", 32'(out_ch), 32'(3));
      tick();
      chk("t4_wrap", 32'(out_ch), 32'(0));
      tick();
      chk("t4_grant_b", 32'(out_ch), 32'(3));

      // Backpressure for three cycles, then drain and refill together
      out_ready = 1'b0;
      #1 chk("t5_in_ready_stall", 32'(in_ready), 32'(0));
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t5_hold_valid", 32'(out_valid), 32'(1));
         chk("t5_hold_ch", 32'(out_ch), 32'(3));
         chk("t5_hold_data", 32'(out_data), 32'(8'h13));
         chk("t5_hold_ready", 32'(in_ready), 32'(0));
      end
      out_ready = 1'b1;
      #1 chk("t5_refill_ready", 32'(in_ready), 32'(4'b0001));
      tick();
      chk("t5_refill_ch", 32'(out_ch), 32'(0));
      chk("t5_refill_data", 32'(out_data), 32'(8'h10));
      chk("t5_refill_valid", 32'(out_valid), 32'(1));

      // Mid-stream reset discards the held word and restores the pointer
      reset_b = 1'b0;
      #1;
      chk("t6_out_valid", 32'(out_valid), 32'(0));
      chk("t6_out_data", 32'(out_data), 32'(0));
      chk("t6_in_ready", 32'(in_ready), 32'(0));
      tick();
      reset_b  = 1'b1;
      in_valid = 4'hF;
      tick();
      chk("t6_first_grant", 32'(out_ch), 32'(0));
      chk("t6_first_data", 32'(out_data), 32'(8'h10));

      // Select mode: unselected-invalid channel, then a valid one
      mode_rr  = 1'b0;
      select   = 2'd2;
      in_valid = 4'b1011;
      #1 chk("t7_sel_invalid", 32'(in_ready), 32'(0));
      select = 2'd1;
      #1 chk("t7_sel_valid", 32'(in_ready), 32'(4'b0010));
      tick();
      chk("t7_out_ch", 32'(out_ch), 32'(1));
      chk("t7_out_data", 32'(out_data), 32'(8'h11));

      // Mode/select change while stalled leaves the held word untouched
      out_ready = 1'b0;
      mode_rr   = 1'b1;
      select    = 2'd3;
      tick();
      chk("t7_held_ch", 32'(out_ch), 32'(1));
      chk("t7_held_data", 32'(out_data), 32'(8'h11));

      // Drain
      in_valid  = 4'b0000;
      out_ready = 1'b1;
      tick();
      chk("drain_valid", 32'(out_valid), 32'(0));
      tick();
      chk("sb_empty", 32'(exp_q.size()), 32'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
